// File: rtl/psum_pkg.sv
// psum_pkg: shared sizes, the ofmap FIFO entry type and the psum post-processing
// function used by psum_drain.
//   PSUM_WIDTH     : width of the signed partial sum coming out of a PE column
//   OUT_WIDTH      : width of the signed ofmap element written to memory
//   ofmap_entry_t  : one buffered result (saturated data plus row-last marker)
//   sat_shift_relu : arithmetic shift, optional ReLU, saturation to OUT_WIDTH
package psum_pkg;

  localparam int PSUM_WIDTH = 10;
  localparam int OUT_WIDTH  = 8;

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] data;
    logic                        last;
  } ofmap_entry_t;

  // Saturation bounds expressed at psum width so the compare stays signed.
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX =
    PSUM_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN =
    PSUM_WIDTH'(-(1 << (OUT_WIDTH - 1)));

  // Floor shift (>>> on a signed value), then ReLU, then clamp to OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] sat_shift_relu(
    input logic signed [PSUM_WIDTH-1:0] psum,
    input int unsigned                  shift,
    input logic                         relu
  );
    logic signed [PSUM_WIDTH-1:0] s;
    s = psum >>> shift;
    if (relu && (s < 0)) begin
      s = '0;
    end
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
    end
    return $signed(s[OUT_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: synchronous FIFO of ofmap_entry_t with registered storage.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : synchronous flush, same effect as reset, highest priority
//   push_i     : write entry_i; accepted when not full or when popping this cycle
//   entry_i    : entry to write
//   pop_i      : remove head entry (ignored when empty)
//   head_o     : head entry, all-zero when empty
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : occupancy 0..DEPTH
module psum_fifo
  import psum_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  ofmap_entry_t             entry_i,
  input  logic                     pop_i,
  output ofmap_entry_t             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int COUNT_W = AW + 1;

  ofmap_entry_t       mem_q [DEPTH];
  ofmap_entry_t       mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == COUNT_W'(DEPTH));
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Storage needs no reset: it is only observed through head_o while non-empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head_o = '0;
    if (!empty_o) begin
      head_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: consumer of a PE column's final partial sums. Each psum is
// shifted, optionally ReLU'd and saturated into a stage register, then queued
// in a small FIFO and streamed out over ready/valid with a per-row last flag.
// The PE cannot be stalled, so results that find the FIFO full are dropped and
// a sticky overflow flag is raised.
//   clk, rst_n     : clock, synchronous active-low reset
//   psum_i         : signed psum from PE
//   psum_valid_i   : psum_i valid this cycle
//   relu_en_i      : clamp negatives to 0, sampled with psum_valid_i
//   clear_i        : synchronous flush of stage, FIFO, column counter, overflow
//   ofmap_o        : signed result at FIFO head (0 when empty)
//   ofmap_valid_o  : FIFO non-empty
//   ofmap_ready_i  : consumer accepts head when valid & ready
//   ofmap_last_o   : head element is last of its row (0 when empty)
//   overflow_o     : sticky, at least one result dropped
//   count_o        : FIFO occupancy
module psum_drain #(
  parameter int PSUM_WIDTH = 10,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 0,
  parameter int DEPTH      = 4,
  parameter int ROW_LEN    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [PSUM_WIDTH-1:0] psum_i,
  input  logic                         psum_valid_i,
  input  logic                         relu_en_i,
  input  logic                         clear_i,
  output logic signed [OUT_WIDTH-1:0]  ofmap_o,
  output logic                         ofmap_valid_o,
  input  logic                         ofmap_ready_i,
  output logic                         ofmap_last_o,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  import psum_pkg::*;

  localparam int            CW       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_LEN - 1);

  logic          stage_valid_q, stage_valid_d;
  ofmap_entry_t  stage_entry_q, stage_entry_d;
  logic [CW-1:0] col_q, col_d;
  logic          overflow_q, overflow_d;

  ofmap_entry_t  head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  assign pop  = !fifo_empty && ofmap_ready_i;
  // Mirrors the FIFO's own acceptance rule so the drop is seen the same cycle.
  assign drop = stage_valid_q && fifo_full && !pop;

  always_comb begin
    stage_valid_d = psum_valid_i;
    stage_entry_d = stage_entry_q;
    col_d         = col_q;
    overflow_d    = overflow_q || drop;

    // The column counter advances on every capture, including ones dropped
    // later, so row alignment survives overflow.
    if (psum_valid_i) begin
      stage_entry_d.data = sat_shift_relu(psum_i, SHIFT, relu_en_i);
      stage_entry_d.last = (col_q == COL_LAST);
      col_d              = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end

    if (clear_i) begin
      stage_valid_d = 1'b0;
      stage_entry_d = '0;
      col_d         = '0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_entry_q <= '0;
      col_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_entry_q <= stage_entry_d;
      col_q         <= col_d;
      overflow_q    <= overflow_d;
    end
  end

  psum_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (stage_valid_q),
    .entry_i (stage_entry_q),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign ofmap_o       = head.data;
  assign ofmap_last_o  = head.last;
  assign ofmap_valid_o = !fifo_empty;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: drives two psum_drain instances (SHIFT=0 and SHIFT=2) with the
// same stimulus and compares them every cycle against a queue-based reference
// model, plus directed checks with literal expected values.
module tb_psum_drain;

  localparam int DEPTH   = 4;
  localparam int ROW_LEN = 4;
  localparam int SH [2]  = '{0, 2};

  logic              clk;
  logic              rst_n;
  logic signed [9:0] psum_i;
  logic              psum_valid_i;
  logic              relu_en_i;
  logic              clear_i;
  logic              ofmap_ready_i;

  logic signed [7:0] ofmap0, ofmap1;
  logic              valid0, valid1, last0, last1, ovf0, ovf1;
  logic [2:0]        count0, count1;

  psum_drain #(.PSUM_WIDTH(10), .OUT_WIDTH(8), .SHIFT(0), .DEPTH(DEPTH), .ROW_LEN(ROW_LEN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
    .relu_en_i(relu_en_i), .clear_i(clear_i), .ofmap_o(ofmap0), .ofmap_valid_o(valid0),
    .ofmap_ready_i(ofmap_ready_i), .ofmap_last_o(last0), .overflow_o(ovf0), .count_o(count0));

  psum_drain #(.PSUM_WIDTH(10), .OUT_WIDTH(8), .SHIFT(2), .DEPTH(DEPTH), .ROW_LEN(ROW_LEN)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
    .relu_en_i(relu_en_i), .clear_i(clear_i), .ofmap_o(ofmap1), .ofmap_valid_o(valid1),
    .ofmap_ready_i(ofmap_ready_i), .ofmap_last_o(last1), .overflow_o(ovf1), .count_o(count1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } m_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one set per instance
  m_t  mq  [2][$];
  m_t  got [2][$];
  bit  sv   [2];
  m_t  st   [2];
  int  mcol [2];
  bit  movf [2];
  int  psum_v;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor division by 2^sh, ReLU, clamp to [-128,127].
  function automatic int ref_val(input int p, input bit relu, input int sh);
    int d;
    int s;
    d = 1 << sh;
    s = p / d;
    if ((p % d != 0) && (p < 0)) s = s - 1;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic logic signed [31:0] d_data(input int k);
    return (k == 0) ? 32'(ofmap0) : 32'(ofmap1);
  endfunction
  function automatic logic signed [31:0] d_valid(input int k);
    return (k == 0) ? {31'd0, valid0} : {31'd0, valid1};
  endfunction
  function automatic logic signed [31:0] d_last(input int k);
    return (k == 0) ? {31'd0, last0} : {31'd0, last1};
  endfunction
  function automatic logic signed [31:0] d_count(input int k);
    return (k == 0) ? {29'd0, count0} : {29'd0, count1};
  endfunction
  function automatic logic signed [31:0] d_ovf(input int k);
    return (k == 0) ? {31'd0, ovf0} : {31'd0, ovf1};
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || clear_i) begin
        mq[k].delete();
        sv[k]   = 0;
        mcol[k] = 0;
        movf[k] = 0;
      end else begin
        bit pop;
        bit ok;
        pop = (mq[k].size() > 0) && ofmap_ready_i;
        ok  = (mq[k].size() < DEPTH) || pop;
        if (pop) void'(mq[k].pop_front());
        if (sv[k]) begin
          if (ok) mq[k].push_back(st[k]);
          else    movf[k] = 1;
        end
        sv[k] = psum_valid_i;
        if (psum_valid_i) begin
          st[k].data = ref_val(psum_v, relu_en_i, SH[k]);
          st[k].last = (mcol[k] == ROW_LEN - 1);
          mcol[k]    = (mcol[k] + 1) % ROW_LEN;
        end
      end
    end
  endtask

  // One clock: record accepted outputs, advance model, sample #1 after edge.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (d_valid(k) === 1 && ofmap_ready_i) begin
        m_t e;
        e.data = d_data(k);
        e.last = d_last(k)[0];
        got[k].push_back(e);
      end
    end
    model_edge();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = mq[k].size();
      check($sformatf("valid%0d", k), d_valid(k), (sz > 0) ? 1 : 0);
      check($sformatf("data%0d", k),  d_data(k),  (sz > 0) ? mq[k][0].data : 0);
      check($sformatf("last%0d", k),  d_last(k),  (sz > 0) ? 32'(mq[k][0].last) : 0);
      check($sformatf("count%0d", k), d_count(k), sz);
      check($sformatf("ovf%0d", k),   d_ovf(k),   32'(movf[k]));
    end
  endtask

  task automatic put(input int p, input bit relu);
    psum_valid_i = 1'b1;
    psum_v       = p;
    psum_i       = p[9:0];
    relu_en_i    = relu;
    tick();
  endtask

  task automatic idle(input int n);
    psum_valid_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    psum_valid_i = 1'b0;
    clear_i      = 1'b1;
    tick();
    clear_i      = 1'b0;
    got[0].delete();
    got[1].delete();
  endtask

  function automatic int rnd_psum();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  initial begin
    int vals [6];
    rst_n         = 1'b0;
    clear_i       = 1'b0;
    psum_valid_i  = 1'b0;
    psum_i        = '0;
    psum_v        = 0;
    relu_en_i     = 1'b0;
    ofmap_ready_i = 1'b1;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_count", d_count(0), 0);
    check("rst_valid", d_valid(0), 0);

    // Latency: one psum appears after exactly two edges
    put(37, 0);
    psum_valid_i = 1'b0;
    check("lat_early_valid", d_valid(0), 0);
    idle(1);
    check("lat_valid", d_valid(0), 1);
    check("lat_data", d_data(0), 37);
    check("lat_last", d_last(0), 0);
    idle(1);
    check("lat_drop_valid", d_valid(0), 0);

    // Saturation / ReLU / floor shift
    do_clear();
    put(300, 0); put(-300, 0); put(-5, 1); put(-5, 0); put(-511, 0); put(-3, 0);
    idle(4);
    check("sat_n0", got[0].size(), 6);
    check("sat_n1", got[1].size(), 6);
    if (got[0].size() == 6 && got[1].size() == 6) begin
      check("sat0_300", got[0][0].data, 127);
      check("sat0_m300", got[0][1].data, -128);
      check("sat0_relu", got[0][2].data, 0);
      check("sat0_m5", got[0][3].data, -5);
      check("sh2_300", got[1][0].data, 75);
      check("sh2_relu", got[1][2].data, 0);
      check("sh2_m5", got[1][3].data, -2);
      check("sh2_m511", got[1][4].data, -128);
      check("sh2_m3", got[1][5].data, -1);
    end

    // Last flag over 9 psums
    do_clear();
    for (int i = 0; i < 9; i++) put(rnd_psum(), 0);
    idle(4);
    check("last_n", got[0].size(), 9);
    for (int i = 0; i < 9 && i < got[0].size(); i++)
      check($sformatf("last_idx%0d", i), 32'(got[0][i].last), (i == 3 || i == 7) ? 1 : 0);

    // Overflow with consumer stalled
    do_clear();
    ofmap_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vals[i] = rnd_psum();
      put(vals[i], 0);
    end
    idle(2);
    check("ovf_count", d_count(0), 4);
    check("ovf_flag", d_ovf(0), 1);
    ofmap_ready_i = 1'b1;
    idle(6);
    check("ovf_drain_n", got[0].size(), 4);
    for (int i = 0; i < 4 && i < got[0].size(); i++)
      check($sformatf("ovf_val%0d", i), got[0][i].data, ref_val(vals[i], 0, 0));
    check("ovf_sticky", d_ovf(0), 1);
    do_clear();
    check("ovf_cleared", d_ovf(0), 0);

    // Full FIFO with push and pop every cycle
    ofmap_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) put(rnd_psum(), 0);
    check("full_count", d_count(0), 4);
    ofmap_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(rnd_psum(), 0);
      check("pp_count", d_count(0), 4);
      check("pp_ovf", d_ovf(0), 0);
    end
    idle(6);

    // Mid-operation reset (m=0) and clear (m=1)
    for (int m = 0; m < 2; m++) begin
      do_clear();
      ofmap_ready_i = 1'b0;
      put(rnd_psum(), 0); put(rnd_psum(), 0); put(rnd_psum(), 0);
      idle(1);
      check("mid_queued", d_count(0), 3);
      if (m == 0) rst_n = 1'b0; else clear_i = 1'b1;
      tick();
      rst_n   = 1'b1;
      clear_i = 1'b0;
      check("mid_count", d_count(0), 0);
      check("mid_valid", d_valid(0), 0);
      got[0].delete();
      ofmap_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) put(rnd_psum(), 0);
      idle(4);
      check("mid_n", got[0].size(), 4);
      if (got[0].size() == 4) begin
        check("mid_first_last", 32'(got[0][0].last), 0);
        check("mid_fourth_last", 32'(got[0][3].last), 1);
      end
    end

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      ofmap_ready_i = ($urandom_range(0, 3) != 0);
      clear_i       = ($urandom_range(0, 63) == 0);
      relu_en_i     = $urandom_range(0, 1);
      psum_v        = rnd_psum();
      psum_i        = psum_v[9:0];
      psum_valid_i  = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_i = 1'b0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
